// File: rtl/cmp_pkg.sv
// cmp_pkg: shared definitions for the 4-bit comparison stage.
//   DEFAULT_WIDTH : operand/result width the comparator is built for
//   cmp_state_e   : operand sequencer FSM states (2-bit encoding)
//   MODE_*        : comparator mode encoding driven on cmp_mode
package cmp_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    WAIT_X = 2'd0,
    WAIT_Y = 2'd1,
    EVAL   = 2'd2,
    HOLD   = 2'd3
  } cmp_state_e;

  localparam logic [1:0] MODE_EQ  = 2'd0;  // x == y, flag in bit 0
  localparam logic [1:0] MODE_XGT = 2'd1;  // x >  y, flag in bit 0
  localparam logic [1:0] MODE_YGT = 2'd2;  // y >  x, flag in bit 0
  localparam logic [1:0] MODE_MAX = 2'd3;  // max(x, y)

endpackage

// File: rtl/cmp_operand_sequencer.sv
// cmp_operand_sequencer: collects x/y operand beats from a valid/ready stream,
// drives the comparator inputs, captures its result and offers it downstream.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_mode       operand beat; mode is sampled only with the y beat
//   in_valid/in_ready     input handshake
//   cmp_x/cmp_y/cmp_mode  registered comparator inputs
//   cmp_o                 comparator result (combinational from cmp_*)
//   out_data/out_valid    registered result stream
//   out_ready             consumer accepts out_data
//   op_count              completed hand-offs, wraps silently
//
// Build option: CMP_SEQ_CHAIN_EN -- after each hand-off the result becomes the
// next x operand and only a y beat is needed per operation.
module cmp_operand_sequencer
  import cmp_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] cmp_x,
  output logic [WIDTH-1:0] cmp_y,
  output logic [1:0]       cmp_mode,
  input  logic [WIDTH-1:0] cmp_o,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] op_count
);

  cmp_state_e state_q;
  // Holds in_ready low through the first cycle after reset release.
  logic       run_q;
  logic       in_hs;
  logic       out_hs;

  always_comb begin
    in_ready = run_q && ((state_q == WAIT_X) || (state_q == WAIT_Y));
    in_hs    = in_valid && in_ready;
    out_hs   = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WAIT_X;
      run_q     <= 1'b0;
      cmp_x     <= '0;
      cmp_y     <= '0;
      cmp_mode  <= MODE_EQ;
      out_data  <= '0;
      out_valid <= 1'b0;
      op_count  <= '0;
    end else begin
      run_q <= 1'b1;
      case (state_q)
        WAIT_X: begin
          if (in_hs) begin
            cmp_x   <= in_data;
            state_q <= WAIT_Y;
          end
        end
        WAIT_Y: begin
          if (in_hs) begin
            cmp_y    <= in_data;
            cmp_mode <= in_mode;
            state_q  <= EVAL;
          end
        end
        EVAL: begin
          out_data  <= cmp_o;
          out_valid <= 1'b1;
          state_q   <= HOLD;
        end
        HOLD: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
`ifdef CMP_SEQ_CHAIN_EN
            cmp_x   <= out_data;
            state_q <= WAIT_Y;
`else
            state_q <= WAIT_X;
`endif
          end
        end
        default: state_q <= WAIT_X;
      endcase
    end
  end

endmodule
